// File: rtl/regfile_write_scheduler.sv
// regfile_write_scheduler: arbitrates ALU/load writebacks onto the register-file write port and tracks pending writes.
// Optional RF_FWD_EN: forward the in-flight rf_* write to decode and mask its hazard.
module regfile_write_scheduler #(
    parameter int MAX_WAIT = 3,
    parameter int NUM_REGS = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       alu_valid,
    input  logic [2:0] alu_rd,
    input  logic       alu_label,
    input  logic [7:0] alu_data,
    output logic       alu_ready,
    input  logic       mem_valid,
    input  logic [2:0] mem_rd,
    input  logic       mem_label,
    input  logic [7:0] mem_data,
    output logic       mem_ready,
    input  logic       issue_valid,
    input  logic [2:0] issue_rd,
    input  logic       issue_label,
    input  logic [2:0] rs1,
    input  logic [2:0] rs2,
    input  logic       label_read,
    output logic       hazard,
    output logic [2:0] rf_rd,
    output logic [7:0] rf_write_data,
    output logic       rf_reg_write,
    output logic       rf_label_write,
    output logic       fwd_valid_a,
    output logic       fwd_valid_b,
    output logic [7:0] fwd_data,
    output logic       illegal_idx
);
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [2:0] LIM = 3'(NUM_REGS);

    logic [CW-1:0] cnt;
    logic [7:0] pend_g, pend_l, set_g, set_l, clr_g, clr_l, pend_sel;
    logic mem_prio, acc, wr_legal, wr_label;
    logic [2:0] wr_rd;
    logic [7:0] wr_data;

    assign mem_prio  = cnt == CW'(MAX_WAIT);
    assign mem_ready = mem_valid && (!alu_valid || mem_prio);
    assign alu_ready = alu_valid && !(mem_valid && mem_prio);
    assign acc       = alu_ready || mem_ready;
    assign wr_rd     = mem_ready ? mem_rd : alu_rd;
    assign wr_data   = mem_ready ? mem_data : alu_data;
    assign wr_label  = mem_ready ? mem_label : alu_label;
    assign wr_legal  = acc && wr_rd < LIM;

    // Bits at indices >= NUM_REGS are never set, so out-of-range sources read 0.
    assign set_g = (issue_valid && !issue_label && issue_rd < LIM) ? 8'(1) << issue_rd : '0;
    assign set_l = (issue_valid && issue_label && issue_rd < LIM) ? 8'(1) << issue_rd : '0;
    assign clr_g = rf_reg_write ? 8'(1) << rf_rd : '0;
    assign clr_l = rf_label_write ? 8'(1) << rf_rd : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt            <= '0;
            pend_g         <= '0;
            pend_l         <= '0;
            rf_rd          <= '0;
            rf_write_data  <= '0;
            rf_reg_write   <= 1'b0;
            rf_label_write <= 1'b0;
            illegal_idx    <= 1'b0;
        end else begin
            cnt            <= mem_ready ? '0 : mem_valid ? cnt + CW'(1) : cnt;
            pend_g         <= (pend_g & ~clr_g) | set_g;
            pend_l         <= (pend_l & ~clr_l) | set_l;
            rf_reg_write   <= wr_legal && !wr_label;
            rf_label_write <= wr_legal && wr_label;
            if (wr_legal) begin
                rf_rd         <= wr_rd;
                rf_write_data <= wr_data;
            end
            if ((acc && !wr_legal) || (issue_valid && issue_rd >= LIM))
                illegal_idx <= 1'b1;
        end
    end

    assign pend_sel = label_read ? pend_l : pend_g;

`ifdef RF_FWD_EN
    logic strobe_sel;
    assign strobe_sel  = label_read ? rf_label_write : rf_reg_write;
    assign fwd_valid_a = strobe_sel && rf_rd == rs1;
    assign fwd_valid_b = strobe_sel && rf_rd == rs2;
    assign fwd_data    = rf_write_data;
`else
    assign fwd_valid_a = 1'b0;
    assign fwd_valid_b = 1'b0;
    assign fwd_data    = '0;
`endif

    assign hazard = (pend_sel[rs1] && !fwd_valid_a) || (pend_sel[rs2] && !fwd_valid_b);
endmodule

// File: tb/tb_regfile_write_scheduler.sv
// tb_regfile_write_scheduler: directed scoreboard bench for regfile_write_scheduler.
module tb_regfile_write_scheduler;
    logic clk = 0, rst_n = 0;
    logic alu_valid = 0, alu_label = 0, mem_valid = 0, mem_label = 0;
    logic issue_valid = 0, issue_label = 0, label_read = 0;
    logic [2:0] alu_rd = 0, mem_rd = 0, issue_rd = 0, rs1 = 0, rs2 = 0;
    logic [7:0] alu_data = 0, mem_data = 0;
    logic alu_ready, mem_ready, hazard, rf_reg_write, rf_label_write;
    logic fwd_valid_a, fwd_valid_b, illegal_idx;
    logic [2:0] rf_rd;
    logic [7:0] rf_write_data, fwd_data;

    typedef struct {logic [2:0] rd; logic [7:0] d; logic l;} wr_t;
    wr_t exp_q[$];
    int errors = 0, checks = 0, wcnt = 0;

    regfile_write_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_label(alu_label), .alu_data(alu_data), .alu_ready(alu_ready),
        .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_label(mem_label), .mem_data(mem_data), .mem_ready(mem_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_label(issue_label),
        .rs1(rs1), .rs2(rs2), .label_read(label_read), .hazard(hazard),
        .rf_rd(rf_rd), .rf_write_data(rf_write_data), .rf_reg_write(rf_reg_write), .rf_label_write(rf_label_write),
        .fwd_valid_a(fwd_valid_a), .fwd_valid_b(fwd_valid_b), .fwd_data(fwd_data), .illegal_idx(illegal_idx)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rf_rd", rf_rd, e.rd);
            check("rf_write_data", rf_write_data, e.d);
            check("rf_reg_write", rf_reg_write, !e.l);
            check("rf_label_write", rf_label_write, e.l);
        end else begin
            check("idle_reg_write", rf_reg_write, 0);
            check("idle_label_write", rf_label_write, 0);
        end
    endtask

    task automatic push(logic [2:0] rd, logic [7:0] d, logic l);
        wr_t e;
        e.rd = rd; e.d = d; e.l = l;
        exp_q.push_back(e);
    endtask

    initial begin
        bit mem_win;
        // reset then idle
        tick();
        tick();
        rst_n = 1;
        tick();
        check("rst_rf_rd", rf_rd, 0);
        check("rst_rf_data", rf_write_data, 0);
        check("rst_illegal", illegal_idx, 0);
        check("rst_alu_ready", alu_ready, 0);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_fwd_data", fwd_data, 0);
        for (int i = 0; i < 8; i++) begin
            rs1 = 3'(i); rs2 = 3'(7 - i); label_read = i[0];
            #1;
            check("rst_hazard", hazard, 0);
            check("rst_fwd_a", fwd_valid_a, 0);
        end
        // single ALU write
        label_read = 0; rs1 = 0; rs2 = 0;
        alu_valid = 1; alu_rd = 2; alu_label = 0; alu_data = 8'h5A;
        #1;
        check("alu_only_ready", alu_ready, 1);
        check("alu_only_mem_ready", mem_ready, 0);
        push(2, 8'h5A, 0);
        tick();
        alu_valid = 0;
        tick();
        // both valid: starvation bound forces mem through on the 4th cycle
        mem_valid = 1; mem_rd = 5; mem_label = 0; mem_data = 8'hC3;
        alu_valid = 1; alu_rd = 3;
        for (int c = 0; c < 5; c++) begin
            alu_data = 8'(8'h10 + c); alu_label = c[0];
            if (c == 4) mem_valid = 0;
            #1;
            mem_win = mem_valid && (!alu_valid || wcnt == 3);
            check("arb_alu_ready", alu_ready, !mem_win);
            check("arb_mem_ready", mem_ready, mem_win);
            if (mem_win) begin
                push(5, 8'hC3, 0);
                wcnt = 0;
            end else begin
                push(3, alu_data, alu_label);
                if (mem_valid) wcnt++;
            end
            tick();
        end
        alu_valid = 0;
        tick();
        // scoreboard hazard on l1 cleared by a load
        issue_valid = 1; issue_rd = 1; issue_label = 1;
        tick();
        issue_valid = 0;
        rs1 = 1; rs2 = 0; label_read = 1;
        #1;
        check("haz_l1", hazard, 1);
        label_read = 0;
        #1;
        check("haz_other_bank", hazard, 0);
        label_read = 1;
        tick();
        check("haz_l1_hold", hazard, 1);
        mem_valid = 1; mem_rd = 1; mem_label = 1; mem_data = 8'h77;
        #1;
        check("load_ready", mem_ready, 1);
        push(1, 8'h77, 1);
        tick();
        mem_valid = 0;
`ifdef RF_FWD_EN
        check("fwd_hazard", hazard, 0);
        check("fwd_valid_a", fwd_valid_a, 1);
        check("fwd_valid_b", fwd_valid_b, 0);
        check("fwd_data", fwd_data, 8'h77);
`else
        check("strobe_hazard", hazard, 1);
        check("nofwd_valid_a", fwd_valid_a, 0);
`endif
        tick();
        check("haz_cleared", hazard, 0);
        // set beats clear on the same edge
        issue_valid = 1; issue_rd = 4; issue_label = 0;
        tick();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 4; alu_label = 0; alu_data = 8'h44;
        push(4, 8'h44, 0);
        tick();
        alu_valid = 0;
        issue_valid = 1; issue_rd = 4; issue_label = 0;
        tick();
        issue_valid = 0;
        rs1 = 4; rs2 = 0; label_read = 0;
        #1;
        check("set_wins", hazard, 1);
        rs1 = 0; rs2 = 4;
        tick();
        check("set_wins_rs2", hazard, 1);
        // illegal index is accepted but never written
        rs1 = 4; rs2 = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 8'hEE;
        #1;
        check("illegal_ready", alu_ready, 1);
        check("illegal_pre", illegal_idx, 0);
        tick();
        alu_valid = 0;
        check("illegal_set", illegal_idx, 1);
        check("illegal_rf_rd", rf_rd, 4);
        tick();
        check("illegal_sticky", illegal_idx, 1);
        check("illegal_no_sb_change", hazard, 1);
        // async reset drops an in-flight strobe
        alu_valid = 1; alu_rd = 0; alu_label = 0; alu_data = 8'h99;
        push(0, 8'h99, 0);
        tick();
        alu_valid = 0;
        rst_n = 0;
        #1;
        check("rst_mid_strobe", rf_reg_write, 0);
        check("rst_mid_rf_rd", rf_rd, 0);
        check("rst_mid_illegal", illegal_idx, 0);
        check("rst_mid_hazard", hazard, 0);
        tick();
        rst_n = 1;
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/regfile_write_scheduler.md
Name: regfile_write_scheduler

Overview:
Shares the single register-file write port between two writeback requesters: ALU results and memory loads. Tracks pending writes in a scoreboard and flags read hazards to the decode stage. Sits between the execute/memory stages and the 8-bit register file, which has general registers a0-a3, v0, c0 and label registers l0-l5. Drives the register file's rd, write_data, reg_write and label_write inputs from registered outputs.

Parameters:
MAX_WAIT, 3, consecutive cycles a pending mem request may lose arbitration before it is forced to win
NUM_REGS, 6, valid register indices per bank (0..NUM_REGS-1); indices 6 and 7 are illegal

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
alu_valid  in  1  ALU writeback request
alu_rd  in  3  ALU destination index
alu_label  in  1  1 = label bank, 0 = general bank
alu_data  in  8  ALU result
alu_ready  out  1  ALU request accepted this cycle (combinational)
mem_valid  in  1  load writeback request
mem_rd  in  3  load destination index
mem_label  in  1  bank select for load
mem_data  in  8  load data
mem_ready  out  1  load request accepted this cycle (combinational)
issue_valid  in  1  decode issued an instruction that will write issue_rd
issue_rd  in  3  destination of issued instruction
issue_label  in  1  bank of issued destination
rs1  in  3  decode source 1
rs2  in  3  decode source 2
label_read  in  1  bank of the decode sources
hazard  out  1  rs1 or rs2 pending in the selected bank (combinational)
rf_rd  out  3  register-file write index (registered)
rf_write_data  out  8  register-file write data (registered)
rf_reg_write  out  1  general-bank write strobe (registered)
rf_label_write  out  1  label-bank write strobe (registered)
fwd_valid_a  out  1  forwarding valid for rs1
fwd_valid_b  out  1  forwarding valid for rs2
fwd_data  out  8  forwarded value (equals rf_write_data)
illegal_idx  out  1  sticky: request or issue targeted index >= NUM_REGS

Behaviour:
- Reset: all outputs 0; scoreboard cleared; wait counter 0; illegal_idx 0.
- Handshake: a request is accepted when valid && ready in the same cycle. A requester holds valid and its fields stable until accepted.
- Arbitration: ALU wins by default. Wait counter increments each cycle that mem_valid is high and the mem request is not accepted. When the counter equals MAX_WAIT, mem wins the next arbitration. The counter clears on mem acceptance.
- With only one request valid, that request is accepted immediately. With neither valid, both readys are 0.
- Latency: the accepted request appears on rf_* on the next rising edge, with exactly one of rf_reg_write or rf_label_write high for one cycle (per the request's label bit). The strobes deassert on the following cycle if no new acceptance occurs. Throughput is one write per cycle.
- Illegal index (rd 6 or 7): the request is accepted (ready=1) but no strobe is generated, illegal_idx is set, and the scoreboard is unchanged. An issue_valid with issue_rd >= 6 also sets illegal_idx and marks nothing. Only reset clears illegal_idx.
- Scoreboard: 2x6 pending bits.
  - issue_valid sets pending[issue_label][issue_rd].
  - A strobe on the rf_* outputs clears pending[bank][rf_rd] on the same edge that the strobe is observed.
  - When set and clear target the same bit on one edge, set wins.
- Hazard: hazard = pending[label_read][rs1] | pending[label_read][rs2]. An index >= 6 never hazards.
- A write for a register that is not pending is still performed; it does not touch other bits.
- Reset mid-operation: in-flight strobes are dropped immediately; a requester must re-present after rst_n rises.

Optional Feature:
RF_FWD_EN: when defined, a source that matches the current rf_* write (same bank, same index, strobe high) has its pending bit masked out of hazard. The matching fwd_valid_a/b is asserted, and fwd_data = rf_write_data. When undefined, fwd_valid_a/b and fwd_data are tied to 0 and hazard uses the raw pending bits.

Test Plan:
- Reset then idle: every output is 0; hazard is 0 for all rs1/rs2.
- alu_valid alone, rd=2, label=0, data=0x5A -> alu_ready=1 at cycle 0; at cycle 1, rf_rd=2, rf_write_data=0x5A, rf_reg_write=1, rf_label_write=0.
- Both requesters held valid continuously, MAX_WAIT=3 -> ALU is accepted on cycles 0-2, mem is accepted on cycle 3, and ALU resumes on cycle 4. mem_data appears on rf_* at cycle 4.
- issue_valid rd=1 label=1, then rs1=1 label_read=1 -> hazard=1 on the following cycles. After a mem write to l1 strobes, hazard=0 (with RF_FWD_EN: hazard=0 and fwd_valid_a=1 during the strobe cycle).
- Issue of rd=4 on the same edge as a strobe clearing rd=4 -> pending stays 1 and hazard persists.
- alu request with rd=7 -> alu_ready=1, no strobe, illegal_idx=1 and it holds until rst_n is low; rst_n asserted mid-strobe -> rf_reg_write falls immediately.
